seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width (legal values 8..64, powers of 2).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port nRST  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port aluop  input  4  opcode: SLL=0000, SRL=0001, ADD=0010, SUB=0011, AND=0100, OR=0101, XOR=0110, NOR=0111, SRA=1000, MUL=1001, SLT=1010, SLTU=1011; all other codes are undefined.
REQ-008 SHALL have ports port_a and port_b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port output_port  output  WIDTH  registered result.
REQ-012 SHALL have ports negative, overflow and zero  output  1 each  registered flags.
REQ-013 SHALL have port busy  output  1  high while a multiply iterates.

Function
REQ-014 SHALL implement states IDLE and MUL; a request is accepted on any edge where in_valid and in_ready are both high.
REQ-015 SHALL drive in_ready = (state==IDLE) and (!out_valid or out_ready), so back-to-back single-cycle ops sustain one op per cycle.
REQ-016 SHALL, for every non-MUL op, register the result and flags on the accept edge and assert out_valid for that edge's next cycle (latency 1).
REQ-017 SHALL keep output_port, the flags and out_valid stable while out_valid is high and out_ready is low.
REQ-018 SHALL clear out_valid on an edge with out_valid and out_ready high, unless a new result is loaded on that same edge, in which case out_valid stays high.
REQ-019 SHALL use only port_b[SHW-1:0] as the shift amount for SLL, SRL and SRA; SRA replicates port_a[WIDTH-1].
REQ-020 SHALL produce for SLT and SLTU a result of zero-extended 1 or 0 (signed and unsigned compare respectively).
REQ-021 SHALL set overflow for ADD when the operand signs are equal and the result sign differs, for SUB when the operand signs differ and the result sign differs from port_a, and 0 for all other ops.
REQ-022 SHALL compute negative = output_port[WIDTH-1] and zero = (output_port==0), both registered together with the result.
REQ-023 SHALL, for an undefined opcode, complete in 1 cycle with result 0, zero=1, negative=0 and overflow=0.
REQ-024 SHALL implement MUL as a shift-add iteration: on accept, enter MUL with busy=1 and iterate exactly WIDTH cycles; result = low WIDTH bits of port_a*port_b, and overflow=0.
REQ-025 SHALL, on the final MUL cycle, load the result, return to IDLE, drop busy, and assert out_valid on the next cycle; out_valid therefore rises WIDTH cycles after the accept edge.
REQ-026 SHALL ignore in_valid while in MUL (in_ready=0) and SHALL ignore operand changes after acceptance.

Reset
REQ-027 SHALL, on a CLK edge with nRST low, set state=IDLE, out_valid=0, busy=0, output_port=0, negative=0, overflow=0 and zero=1.
REQ-028 SHALL abort a multiply in progress when reset is applied mid-operation, with no result produced.
REQ-029 SHALL drive in_ready=0 during the reset cycle and in_ready=1 on the first cycle after nRST goes high.

Configuration
REQ-030 SHALL support macro SEQ_ALU_MUL_EN: when defined, MUL behaves per REQ-024/025; when undefined, no multiplier logic is built, MUL is treated as an undefined opcode (REQ-023), and busy is tied to 0.

Verification
REQ-031 SHALL cover: WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> out_valid 1 cycle later, output_port 0x80000000, overflow=1, negative=1.
REQ-032 SHALL cover: SUB 5-5 followed immediately by SLT 0xFFFFFFFF,1 with out_ready=1 -> results 0 (zero=1) then 1 on consecutive cycles.
REQ-033 SHALL cover: SRA 0x80000000 by port_b=0x24 -> shift amount 4, result 0xF8000000.
REQ-034 SHALL cover: SEQ_ALU_MUL_EN defined, MUL 0x00010003*0x00000005 -> busy for 32 cycles, in_ready=0, result 0x0005000F; with the macro undefined -> result 0 after 1 cycle.
REQ-035 SHALL cover: out_ready held low for 3 cycles with a result pending -> output_port and flags stable, in_ready=0, then one transfer.
REQ-036 SHALL cover: nRST low at MUL cycle 10 -> out_valid never rises, all outputs at reset values, in_ready=1 on the first cycle after nRST goes high.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request port and a valid/ready
// result port. Single-cycle ops register their result on the accept edge.
// MUL is an iterative shift-add that takes WIDTH cycles.
//
// Configuration macro: SEQ_ALU_MUL_EN
//   defined   : MUL (4'b1001) runs the shift-add multiplier, busy is high
//               while it iterates
//   undefined : no multiplier is built, MUL decodes as an undefined opcode,
//               busy is tied low
//
// Ports
//   CLK          in   rising-edge clock
//   nRST         in   synchronous active-low reset
//   in_valid     in   operation request
//   in_ready     out  block can accept a request
//   aluop[3:0]   in   opcode
//   port_a/b     in   operands, WIDTH bits
//   out_valid    out  result held and valid
//   out_ready    in   consumer takes the result
//   output_port  out  registered result, WIDTH bits
//   negative     out  registered result[WIDTH-1]
//   overflow     out  registered signed overflow (ADD/SUB only)
//   zero         out  registered result==0
//   busy         out  multiply in progress
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | accepting requests, single-cycle ops complete
// MUL   | shift-add multiply iterating, requests blocked
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_port,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             is_mul;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             load_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  assign is_mul = (aluop == 4'b1001);
  assign busy   = (state_q == MUL);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  // nRST gates in_ready so nothing is accepted on the reset edge itself.
  assign in_ready = nRST && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign output_port = result_q;
  assign negative    = neg_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    shamt   = port_b[SHW-1:0];
    case (aluop)
      OP_SLL:  alu_res = port_a << shamt;
      OP_SRL:  alu_res = port_a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(port_a) >>> shamt);
      OP_ADD: begin
        alu_res = port_a + port_b;
        alu_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = port_a - port_b;
        alu_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_AND:  alu_res = port_a & port_b;
      OP_OR:   alu_res = port_a | port_b;
      OP_XOR:  alu_res = port_a ^ port_b;
      OP_NOR:  alu_res = ~(port_a | port_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (port_a < port_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    load        = 1'b0;
    load_val    = '0;
    load_ovf    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MUL;
`ifdef SEQ_ALU_MUL_EN
            cnt_d    = CW'(WIDTH - 1);
            acc_d    = '0;
            mcand_d  = port_a;
            mplier_d = port_b;
`endif
          end else begin
            load     = 1'b1;
            load_val = alu_res;
            load_ovf = alu_ovf;
          end
        end
      end
      MUL: begin
`ifdef SEQ_ALU_MUL_EN
        // One partial product per cycle; after WIDTH steps acc holds the
        // low WIDTH bits of the product.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          load     = 1'b1;
          load_val = acc_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      result_d    = load_val;
      neg_d       = load_val[WIDTH-1];
      zero_d      = (load_val == '0);
      ovf_d       = load_ovf;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
`ifdef SEQ_ALU_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluop;
  logic [W-1:0] port_a;
  logic [W-1:0] port_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] output_port;
  logic         negative;
  logic         overflow;
  logic         zero;
  logic         busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   flags;  // {negative, overflow, zero}
  } exp_t;

  exp_t sbq[$];

  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_out;
  logic [2:0]   prev_flags;

  seq_alu #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aluop       (aluop),
    .port_a      (port_a),
    .port_b      (port_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_port (output_port),
    .negative    (negative),
    .overflow    (overflow),
    .zero        (zero),
    .busy        (busy)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] r;
    logic         v;
    logic [4:0]   sh;
    r  = '0;
    v  = 1'b0;
    sh = b[4:0];
    case (op)
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
      end
      OP_ADD: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  r = a * b;
`endif
      OP_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'b0, (a < b)};
      default: r = '0;
    endcase
    e.res   = r;
    e.flags = {r[W-1], v, (r == '0)};
    return e;
  endfunction

  // Scoreboard: push on handshake, pop on result transfer, and hold checks.
  always @(negedge CLK) begin
    if (!nRST) begin
      sbq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", output_port, prev_out);
        chk("hold_flags", 32'({negative, overflow, zero}), 32'(prev_flags));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(out_valid), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_res", output_port, e.res);
          chk("sb_flags", 32'({negative, overflow, zero}), 32'(e.flags));
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(aluop, port_a, port_b));
      hold_prev  = out_valid && !out_ready;
      prev_out   = output_port;
      prev_flags = {negative, overflow, zero};
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    aluop    = op;
    port_a   = a;
    port_b   = b;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_result"}, output_port, 0);
    chk({tag, "_flags"}, 32'({negative, overflow, zero}), 32'h1);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    int rises;
    int t;
    logic [W-1:0] ra, rb;
    nRST      = 1'b0;
    in_valid  = 1'b0;
    aluop     = '0;
    port_a    = '0;
    port_b    = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge CLK);
    check_reset("rst0");
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst0_release_in_ready", 32'(in_ready), 1);

    // ADD overflow, latency 1
    @(posedge CLK); #1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_res", output_port, 32'h8000_0000);
    chk("add_flags", 32'({negative, overflow, zero}), 32'h6);

    // SUB then SLT back to back
    @(posedge CLK); #1;
    aluop = OP_SUB; port_a = 32'd5; port_b = 32'd5; in_valid = 1'b1;
    @(negedge CLK);
    chk("b2b_rdy0", 32'(in_ready), 1);
    @(posedge CLK); #1;
    aluop = OP_SLT; port_a = 32'hFFFF_FFFF; port_b = 32'd1;
    @(negedge CLK);
    chk("b2b_v0", 32'(out_valid), 1);
    chk("b2b_r0", output_port, 0);
    chk("b2b_z0", 32'(zero), 1);
    chk("b2b_rdy1", 32'(in_ready), 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_v1", 32'(out_valid), 1);
    chk("b2b_r1", output_port, 1);

    // SRA uses only the low shift bits
    @(posedge CLK); #1;
    issue(OP_SRA, 32'h8000_0000, 32'h0000_0024);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("sra_res", output_port, 32'hF800_0000);

    // Directed op mix, back to back
    @(posedge CLK); #1;
    issue(OP_SLL,  32'h0000_00F1, 32'h0000_0021);
    issue(OP_SRL,  32'h8000_0000, 32'd31);
    issue(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00);
    issue(OP_OR,   32'hF000_0000, 32'h0000_000F);
    issue(OP_XOR,  32'hAAAA_5555, 32'hAAAA_5555);
    issue(OP_NOR,  32'h0000_0000, 32'h0000_0000);
    issue(OP_SUB,  32'h8000_0000, 32'h0000_0001);
    issue(OP_SUB,  32'h0000_0003, 32'h0000_0007);
    issue(OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    @(negedge CLK);

    // MUL
    @(posedge CLK); #1;
    issue(OP_MUL, 32'h0001_0003, 32'h0000_0005);
    in_valid = 1'b0;
    port_a = $urandom;
    port_b = $urandom;
`ifdef SEQ_ALU_MUL_EN
    for (int i = 0; i < W; i++) begin
      @(negedge CLK);
      chk("mul_busy", 32'(busy), 1);
      chk("mul_in_ready", 32'(in_ready), 0);
    end
    @(negedge CLK);
    chk("mul_done_valid", 32'(out_valid), 1);
    chk("mul_done_busy", 32'(busy), 0);
    chk("mul_res", output_port, 32'h0005_000F);
`else
    @(negedge CLK);
    chk("mul_undef_valid", 32'(out_valid), 1);
    chk("mul_undef_busy", 32'(busy), 0);
    chk("mul_undef_res", output_port, 0);
    chk("mul_undef_zero", 32'(zero), 1);
`endif

    // Back-pressure for 3 cycles, then one transfer
    @(posedge CLK); #1;
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_res", output_port, 32'd7);
      chk("stall_rdy", 32'(in_ready), 0);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("stall_xfer_valid", 32'(out_valid), 1);
    @(negedge CLK);
    chk("stall_after_xfer", 32'(out_valid), 0);

    // Reset during a multiply
    @(posedge CLK); #1;
    issue(OP_MUL, 32'h0000_1234, 32'h0000_5678);
    in_valid = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(negedge CLK);
`ifdef SEQ_ALU_MUL_EN
    chk("midrst_busy_before", 32'(busy), 1);
`endif
    chk("midrst_in_ready_low", 32'(in_ready), 0);
    @(negedge CLK);
    check_reset("midrst");
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("midrst_release_in_ready", 32'(in_ready), 1);
    rises = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) rises++;
    end
    chk("midrst_no_result", rises, 0);

    // Random ops with random back-pressure
    @(posedge CLK); #1;
    rand_rdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'h7FFF_FFFF;
        2:       ra = 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 1) == 0) ? ra : $urandom;
      issue(4'($urandom_range(0, 15)), ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge CLK); #1;
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge CLK); #1;
    out_ready = 1'b1;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("sb_drained", sbq.size(), 0);
    @(negedge CLK);
    chk("final_out_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
